// File: rtl/seq_divider.sv
// seq_divider - iterative radix-2 restoring divider.
//
// Produces one quotient bit per clock, MSB first, so a WIDTH-bit division
// completes WIDTH+1 cycles after start is accepted. A zero divisor skips the
// iteration and completes one cycle after acceptance.
//
// Optional build macro: SIGNED_DIV_EN
//   - Defined: the operands are two's complement, and the division truncates
//     toward zero.
//   - Undefined: the divider is purely unsigned.
//
// Ports:
//   clk          system clock; every flop updates on the rising edge
//   rst          asynchronous reset, active low
//   start        requests a division; only looked at while idle
//   dividend     WIDTH-bit dividend, captured on the edge that accepts start
//   divisor      WIDTH-bit divisor, captured on the edge that accepts start
//   busy         high from the acceptance edge until the result edge
//   done         one-cycle pulse; quotient/remainder are valid
//   quotient     registered quotient; held until the next completion
//   remainder    registered remainder; held until the next completion
//   div_by_zero  registered; set together with done when the divisor was 0
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  // Trial subtraction for one restoring step.
  //   - The partial remainder is always below the divisor.
  //   - So the shifted value fits in WIDTH+1 bits.
  //   - The extra top bit of trial is the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  // Next-state and datapath logic.
  //   - Acceptance captures the operands (magnitudes in signed builds).
  //   - CALC runs one restoring step per edge.
  //   - FINISH publishes the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH);
          zero_d = (divisor == '0);
`ifdef SIGNED_DIV_EN
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
          dvs_d  = divisor[WIDTH-1] ? -divisor : divisor;
          // A zero divisor reports the dividend untouched, so keep the raw value.
          if (divisor == '0)
            dvd_d = dividend;
          else
            dvd_d = dividend[WIDTH-1] ? -dividend : dividend;
`else
          dvs_d  = divisor;
          dvd_d  = dividend;
`endif
          state_d = (divisor == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        // The dividend register doubles as the quotient shift register.
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = FINISH;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        state_d = IDLE;
        if (zero_q) begin
          quot_d = '1;
          remo_d = dvd_q;
        end else begin
`ifdef SIGNED_DIV_EN
          quot_d = qneg_q ? -dvd_q : dvd_q;
          remo_d = rneg_q ? -rem_q : rem_q;
`else
          quot_d = dvd_q;
          remo_d = rem_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  //   - Reset clears everything.
  //   - An operation in flight is abandoned without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
